imm_gen_pipe: RTL

//  Registered, parametrised RISC-V immediate generator with valid/ready handshake, sitting between fetch and decode/execute.

---
 rtl/imm_gen_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with valid/ready handshake, illegal-encoding
// flagging, a saturating illegal counter and a pass-through sideband tag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] unk_count
);
    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    typedef enum logic [6:0] {
        OPC_LOAD    = 7'b0000011,
        OPC_FENCE   = 7'b0001111,
        OPC_OPIMM   = 7'b0010011,
        OPC_AUIPC   = 7'b0010111,
        OPC_OPIMM32 = 7'b0011011,
        OPC_STORE   = 7'b0100011,
        OPC_OP      = 7'b0110011,
        OPC_LUI     = 7'b0110111,
        OPC_OP32    = 7'b0111011,
        OPC_BRANCH  = 7'b1100011,
        OPC_JALR    = 7'b1100111,
        OPC_JAL     = 7'b1101111,
        OPC_SYSTEM  = 7'b1110011
    } opc_e;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    fmt_e            fmt_q;
    logic            dec_ill;
    logic            is_shift;
    logic            accept;

    // Signed casts sign-extend every format from in_inst[31] to XLEN.
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    assign is_shift = (in_inst[13:12] == 2'b01);

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (in_inst[6:0])
            OPC_OPIMM: begin
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        dec_imm = XLEN'(in_inst[25:20]);
                    end else begin
                        dec_imm = XLEN'(in_inst[24:20]);
                        dec_ill = in_inst[25];
                    end
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
            end
            OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
            end
            OPC_OPIMM32: begin
                if (XLEN != 64) begin
                    dec_ill = 1'b1;
                end else if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = XLEN'(in_inst[24:20]);
                    dec_ill = in_inst[25];
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
            end
            OPC_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = imm_s;
            end
            OPC_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = imm_b;
            end
            OPC_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = imm_j;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = imm_u;
            end
            OPC_SYSTEM: begin
                if (in_inst[14]) begin
                    dec_fmt = FMT_ZIMM;
                    dec_imm = XLEN'(in_inst[19:15]);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
            end
            OPC_OP:   dec_ill = 1'b0;
            OPC_OP32: dec_ill = (XLEN != 64);
            default:  dec_ill = 1'b1;
        endcase
    end

    assign in_ready = ~reset & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign out_fmt  = fmt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            fmt_q       <= FMT_NONE;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            unk_count   <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (accept)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (accept) begin
                out_imm     <= dec_imm;
                fmt_q       <= dec_fmt;
                out_illegal <= dec_ill;
                out_tag     <= in_tag;
                if (dec_ill && (unk_count != '1))
                    unk_count <= unk_count + CNT_W'(1);
            end
        end
    end
endmodule
